// File: rtl/rv32i_data_mem.sv
// ============================================================================
//  Module      : rv32i_data_mem
//  Description : Single-port data memory for the rv32i core behind a
//                request/response handshake. Supports byte/half/word
//                stores with lane enables, sign/zero-extended loads and a
//                configurable read latency (1..15 cycles).
//  Optional    : DMEM_MISALIGN_ERR_EN - when defined, misaligned accesses,
//                reserved sizes and out-of-range addresses raise rsp_err
//                and are suppressed; when undefined they alias/align.
//  Ports       : clk, rst (async, active-low)
//                req_valid/req_ready/req_write/req_addr/req_size/
//                req_unsigned/req_wdata   - request channel
//                rsp_valid/rsp_ready/rsp_rdata/rsp_err - response channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_data_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             upper_nz;
  logic             err;
  logic             accept;
  logic [31:0]      word_rd;
  logic [31:0]      shifted;
  logic [31:0]      ld_data;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;

  assign idx     = req_addr[IDX_W+1:2];
  assign lane    = req_addr[1:0];
  assign accept  = req_valid & req_ready & (state == S_IDLE);
  assign word_rd = mem[idx];

  // Address bits above the word index (absent when ADDR_W exactly covers it)
  generate
    if (ADDR_W > IDX_W + 2) begin : g_upper
      assign upper_nz = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

`ifdef DMEM_MISALIGN_ERR_EN
  assign err = ((req_size == 2'b01) & lane[0])
             | ((req_size == 2'b10) & (lane != 2'b00))
             |  (req_size == 2'b11)
             |  upper_nz;
`else
  // Out-of-range bits alias and low bits are simply dropped for wide accesses
  logic unused_upper;
  assign unused_upper = upper_nz;
  assign err          = 1'b0;
`endif

  // Lane steering: stores replicate the datum into every lane and let the
  // byte enables pick; loads shift the addressed lane down to bit 0.
  // Reserved size 11 falls into the word branch.
  always_comb begin
    shifted = '0;
    ld_data = '0;
    wr_data = '0;
    wr_be   = '0;
    case (req_size)
      2'b00: begin
        shifted = word_rd >> {lane, 3'b000};
        ld_data = req_unsigned ? {24'b0, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
        wr_data = {4{req_wdata[7:0]}};
        wr_be   = 4'b0001 << lane;
      end
      2'b01: begin
        shifted = word_rd >> {lane[1], 4'b0000};
        ld_data = req_unsigned ? {16'b0, shifted[15:0]}
                               : {{16{shifted[15]}}, shifted[15:0]};
        wr_data = {2{req_wdata[15:0]}};
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        shifted = word_rd;
        ld_data = word_rd;
        wr_data = req_wdata;
        wr_be   = 4'b1111;
      end
    endcase
  end

  // Storage array: never reset, written only on an accepted error-free store
  always_ff @(posedge clk) begin
    if (accept && req_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Control FSM. WAIT always spans LATENCY edges (counter loaded with
  // LATENCY-1 on accept) so rsp_valid rises exactly LATENCY edges after the
  // accept edge. Response data is captured at accept and then held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_WAIT;
            cnt       <= LAT_M1;
            req_ready <= 1'b0;
            rsp_rdata <= (req_write || err) ? 32'h0 : ld_data;
            rsp_err   <= err;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_data_mem.sv
// ============================================================================
//  Module      : tb_rv32i_data_mem
//  Description : Self-checking bench for rv32i_data_mem. Two instances share
//                the request fields: u_dut0 (LATENCY=1) runs a table of
//                directed vectors, u_dut4 (LATENCY=4) covers latency and
//                reset-during-wait. Hand sequences cover reset and
//                response back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_data_mem;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        val0 = 1'b0, val1 = 1'b0;
  logic        rdy0, rdy1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_data_mem #(.DEPTH_WORDS(256), .ADDR_W(32), .LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(val0), .req_ready(rdy0), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0)
  );

  rv32i_data_mem #(.DEPTH_WORDS(256), .ADDR_W(32), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(val1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endfunction

  // One complete transaction; returns data, error flag and the number of
  // edges from accept to rsp_valid.
  task automatic txn(input int which, input vec_t v,
                     output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    rd = '0; er = 1'b0; lat = -1;
    while (!((which == 0) ? rdy0 : rdy1) && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 40) begin
      chk("req_ready_timeout", 32'(guard), 32'd0);
      return;
    end
    req_write = v.wr; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    if (which == 0) val0 = 1'b1; else val1 = 1'b1;
    @(posedge clk); #1;
    val0 = 1'b0; val1 = 1'b0;
    lat = 0;
    while (!((which == 0) ? rv0 : rv1) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = (which == 0) ? rd0 : rd1;
    er = (which == 0) ? er0 : er1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        stale;
    vec_t        v;

    //            wr    addr          sz     uns   wdata          exp_rdata                          err
    vecs[0]  = '{1'b1, 32'h10,  2'b10, 1'b0, 32'hDEADBEEF, 32'h0,                               1'b0};
    vecs[1]  = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'hDEADBEEF,                        1'b0};
    vecs[2]  = '{1'b1, 32'h13,  2'b00, 1'b0, 32'h00000080, 32'h0,                               1'b0};
    vecs[3]  = '{1'b0, 32'h13,  2'b00, 1'b0, 32'h0,        32'hFFFFFF80,                        1'b0};
    vecs[4]  = '{1'b0, 32'h13,  2'b00, 1'b1, 32'h0,        32'h00000080,                        1'b0};
    vecs[5]  = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'h80ADBEEF,                        1'b0};
    vecs[6]  = '{1'b1, 32'h12,  2'b01, 1'b0, 32'h00008001, 32'h0,                               1'b0};
    vecs[7]  = '{1'b0, 32'h12,  2'b01, 1'b0, 32'h0,        32'hFFFF8001,                        1'b0};
    vecs[8]  = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'h8001BEEF,                        1'b0};
    vecs[9]  = '{1'b0, 32'h10,  2'b01, 1'b1, 32'h0,        32'h0000BEEF,                        1'b0};
    vecs[10] = '{1'b0, 32'h11,  2'b00, 1'b0, 32'h0,        32'hFFFFFFBE,                        1'b0};
    vecs[11] = '{1'b1, 32'h20,  2'b10, 1'b0, 32'h0,        32'h0,                               1'b0};
    vecs[12] = '{1'b1, 32'h21,  2'b00, 1'b0, 32'h123456FF, 32'h0,                               1'b0};
    vecs[13] = '{1'b0, 32'h20,  2'b10, 1'b1, 32'h0,        32'h0000FF00,                        1'b0};
    vecs[14] = '{1'b1, 32'h10,  2'b10, 1'b0, 32'hAABBCCDD, 32'h0,                               1'b0};
    vecs[15] = '{1'b0, 32'h11,  2'b01, 1'b0, 32'h0,        E ? 32'h0 : 32'hFFFFCCDD,            E};
    vecs[16] = '{1'b1, 32'h00,  2'b10, 1'b0, 32'h11111111, 32'h0,                               1'b0};
    vecs[17] = '{1'b1, 32'h400, 2'b10, 1'b0, 32'h12345678, 32'h0,                               E};
    vecs[18] = '{1'b0, 32'h00,  2'b10, 1'b0, 32'h0,        E ? 32'h11111111 : 32'h12345678,     1'b0};
    vecs[19] = '{1'b0, 32'h10,  2'b11, 1'b0, 32'h0,        E ? 32'h0 : 32'hAABBCCDD,            E};
    vecs[20] = '{1'b0, 32'h12,  2'b10, 1'b0, 32'h0,        E ? 32'h0 : 32'hAABBCCDD,            E};
    vecs[21] = '{1'b0, 32'h13,  2'b01, 1'b1, 32'h0,        E ? 32'h0 : 32'h0000AABB,            E};
    vecs[22] = '{1'b0, 32'h401, 2'b00, 1'b0, 32'h0,        E ? 32'h0 : 32'h00000056,            E};

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rv0), 32'd0);
    chk("rst_req_ready", 32'(rdy0), 32'd0);
    chk("rst_rsp_rdata", rd0, 32'h0);
    chk("rst_rsp_err", 32'(er0), 32'd0);
    chk("rst_req_ready4", 32'(rdy1), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_req_ready_same_cycle", 32'(rdy0), 32'd0);
    @(posedge clk); #1;
    chk("rel_req_ready_next", 32'(rdy0), 32'd1);

    // ---- Table-driven vectors on LATENCY=1 ----
    for (int i = 0; i < NV; i++) begin
      txn(0, vecs[i], rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
    end

    // ---- Latency 4 ----
    v = '{1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    txn(1, v, rd, er, lat);
    chk("l4_sw_latency", 32'(lat), 32'd4);
    chk("l4_sw_rdata", rd, 32'h0);
    v = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0};
    txn(1, v, rd, er, lat);
    chk("l4_lw_latency", 32'(lat), 32'd4);
    chk("l4_lw_rdata", rd, 32'hDEADBEEF);

    // ---- Back-pressure on LATENCY=1 (word 0x10 = AABBCCDD, 0x20 = 0000FF00) ----
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    val0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_valid_rise", 32'(rv0), 32'd1);
    req_addr = 32'h20;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", k), 32'(rv0), 32'd1);
      chk($sformatf("bp_hold%0d_rdata", k), rd0, 32'hAABBCCDD);
      chk($sformatf("bp_hold%0d_ready", k), 32'(rdy0), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rv0), 32'd0);
    chk("bp_release_ready", 32'(rdy0), 32'd1);
    @(posedge clk); #1;
    val0 = 1'b0;
    chk("bp_second_accept", 32'(rdy0), 32'd0);
    @(posedge clk); #1;
    chk("bp_second_valid", 32'(rv0), 32'd1);
    chk("bp_second_rdata", rd0, 32'h0000FF00);
    @(posedge clk); #1;

    // ---- Reset in the middle of WAIT (LATENCY=4) ----
    req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10;
    val1 = 1'b1;
    @(posedge clk); #1;
    val1 = 1'b0;
    @(posedge clk); #1;
    chk("midwait_valid_before", 32'(rv1), 32'd0);
    rst = 1'b0;
    #1;
    chk("midwait_rst_valid", 32'(rv1), 32'd0);
    chk("midwait_rst_ready", 32'(rdy1), 32'd0);
    chk("midwait_rst_rdata", rd1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    @(posedge clk); #1;
    chk("midwait_rel_ready", 32'(rdy1), 32'd1);
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rv1 || rv0) stale = 1'b1;
    end
    chk("midwait_no_stale_rsp", 32'(stale), 32'd0);

    // ---- Store accepted just before reset stays committed ----
    req_write = 1'b1; req_addr = 32'h30; req_size = 2'b10; req_wdata = 32'h5A5A5A5A;
    val1 = 1'b1;
    @(posedge clk); #1;
    val1 = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    v = '{1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0};
    txn(1, v, rd, er, lat);
    chk("rst_store_kept", rd, 32'h5A5A5A5A);
    chk("rst_store_latency", 32'(lat), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
